// File: rtl/modn_counter_fsm.sv
// ---------------------------------------------------------------------------
// modn_counter_fsm
//   Modulo-N counter with a small run-control state machine (IDLE/RUN/DONE).
//   Used as a cyclic or one-shot index / timebase for datapath blocks.
//
//   Parameters
//     MODULUS  count range 0..MODULUS-1 (>= 2)
//     WIDTH    width of count/load_val, 2**WIDTH >= MODULUS
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous active-high reset
//     clr       synchronous clear (count=0, state=IDLE)
//     start     start/restart a run, latches dir and one_shot
//     stop      RUN -> IDLE, count held
//     en        count enable, effective only in RUN
//     dir       0 = up, 1 = down (sampled at start)
//     one_shot  1 = stop at terminal, 0 = wrap (sampled at start)
//     load      parallel load of count (value clamped to MODULUS-1)
//     load_val  load value
//     count     registered count
//     tc        combinational terminal-count flag (RUN & en & at terminal)
//     wrap      registered one-cycle pulse after a wrap update
//     done      registered, high while in DONE
//     busy      registered, high while in RUN
// ---------------------------------------------------------------------------
module modn_counter_fsm #(
  parameter int MODULUS = 3,
  parameter int WIDTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             busy
);

  if (MODULUS < 2) begin : g_bad_modulus
    $error("modn_counter_fsm: MODULUS must be 2 or above");
  end

  if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
    $error("modn_counter_fsm: WIDTH too small, need 2**WIDTH >= MODULUS");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] count_n;
  logic             dir_q;
  logic             dir_n;
  logic             os_q;
  logic             os_n;
  logic             wrap_n;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] origin;
  logic             at_term;

  // Saturate an out-of-range load value to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Terminal/origin follow the direction latched at the last start.
  assign terminal = dir_q ? '0 : CNT_MAX;
  assign origin   = dir_q ? CNT_MAX : '0;
  assign at_term  = (count == terminal);
  assign tc       = (state == S_RUN) & en & at_term;

  // Next-state decode; priority clr > load > start > stop > count step.
  always_comb begin
    state_n = state;
    count_n = count;
    dir_n   = dir_q;
    os_n    = os_q;
    wrap_n  = 1'b0;
    if (clr) begin
      count_n = '0;
      state_n = S_IDLE;
    end else if (load) begin
      count_n = clamp_load(load_val);
      // RUN keeps running (without stepping); DONE and any stray
      // encoding fall back to IDLE.
      if (state != S_RUN) state_n = S_IDLE;
    end else if (start) begin
      dir_n   = dir;
      os_n    = one_shot;
      count_n = dir ? CNT_MAX : '0;
      state_n = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (stop) begin
            state_n = S_IDLE;
          end else if (en) begin
            if (at_term) begin
              if (os_q) begin
                state_n = S_DONE;
              end else begin
                count_n = origin;
                wrap_n  = 1'b1;
              end
            end else begin
              count_n = dir_q ? (count - WIDTH'(1)) : (count + WIDTH'(1));
            end
          end
        end
        S_IDLE, S_DONE: begin
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State register; busy/done are decoded from the next state so they
  // rise in the same cycle the state is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      dir_q <= 1'b0;
      os_q  <= 1'b0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      dir_q <= dir_n;
      os_q  <= os_n;
      wrap  <= wrap_n;
      busy  <= (state_n == S_RUN);
      done  <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_modn_counter_fsm.sv
// ---------------------------------------------------------------------------
// tb_modn_counter_fsm
//   Self-checking bench for modn_counter_fsm. Two instances (MODULUS=3 and
//   MODULUS=5) share the control inputs; a modular-arithmetic reference model
//   tracks both. A vector table covers the basic wrap sequence, hand-written
//   sequences cover one-shot, load clamp, priority, enable gating and async
//   reset, and a randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_modn_counter_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr, start, stop, en, dir, one_shot, load;
  logic [2:0] lv;
  logic [1:0] c3;
  logic [2:0] c5;
  logic       tc3, w3, d3, b3;
  logic       tc5, w5, d5, b5;

  modn_counter_fsm #(.MODULUS(3), .WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .stop(stop), .en(en),
    .dir(dir), .one_shot(one_shot), .load(load), .load_val(lv[1:0]),
    .count(c3), .tc(tc3), .wrap(w3), .done(d3), .busy(b3)
  );

  modn_counter_fsm #(.MODULUS(5), .WIDTH(3)) dut5 (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .stop(stop), .en(en),
    .dir(dir), .one_shot(one_shot), .load(load), .load_val(lv),
    .count(c5), .tc(tc5), .wrap(w5), .done(d5), .busy(b5)
  );

  int n_pass  = 0;
  int n_total = 0;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int mods[2] = '{3, 5};
  int m_st[2], m_cnt[2], m_dir[2], m_os[2], m_wrap[2];
  int tc_pre[2];

  typedef struct {
    logic       clr, start, stop, en, dir, os, load;
    logic [2:0] lv;
    int         e_cnt, e_tc, e_wrap, e_busy, e_done;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int out_cnt(input int i);
    return (i == 0) ? int'(c3) : int'(c5);
  endfunction
  function automatic int out_tc(input int i);
    return (i == 0) ? int'(tc3) : int'(tc5);
  endfunction
  function automatic int out_wrap(input int i);
    return (i == 0) ? int'(w3) : int'(w5);
  endfunction
  function automatic int out_busy(input int i);
    return (i == 0) ? int'(b3) : int'(b5);
  endfunction
  function automatic int out_done(input int i);
    return (i == 0) ? int'(d3) : int'(d5);
  endfunction
  function automatic int lv_of(input int i);
    return (i == 0) ? int'(lv[1:0]) : int'(lv);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_cnt[i] = 0; m_dir[i] = 0; m_os[i] = 0; m_wrap[i] = 0;
    end
  endtask

  function automatic int model_tc(input int i);
    int term;
    term = (m_dir[i] != 0) ? 0 : mods[i] - 1;
    return (m_st[i] == M_RUN && en && m_cnt[i] == term) ? 1 : 0;
  endfunction

  // One clock edge of the reference: counting is modular arithmetic,
  // a wrap is a step taken from the terminal value.
  task automatic model_edge(input int i);
    int m, term, v;
    m    = mods[i];
    term = (m_dir[i] != 0) ? 0 : m - 1;
    v    = lv_of(i);
    m_wrap[i] = 0;
    if (clr) begin
      m_cnt[i] = 0;
      m_st[i]  = M_IDLE;
    end else if (load) begin
      m_cnt[i] = (v < m) ? v : m - 1;
      if (m_st[i] == M_DONE) m_st[i] = M_IDLE;
    end else if (start) begin
      m_dir[i] = int'(dir);
      m_os[i]  = int'(one_shot);
      m_cnt[i] = dir ? m - 1 : 0;
      m_st[i]  = M_RUN;
    end else if (stop) begin
      if (m_st[i] == M_RUN) m_st[i] = M_IDLE;
    end else if (m_st[i] == M_RUN && en) begin
      if (m_cnt[i] == term && m_os[i] != 0) begin
        m_st[i] = M_DONE;
      end else begin
        m_wrap[i] = (m_cnt[i] == term) ? 1 : 0;
        m_cnt[i]  = (m_cnt[i] + ((m_dir[i] != 0) ? m - 1 : 1)) % m;
      end
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.m%0d.count", tag, mods[i]), out_cnt(i), m_cnt[i]);
      chk($sformatf("%s.m%0d.wrap", tag, mods[i]), out_wrap(i), m_wrap[i]);
      chk($sformatf("%s.m%0d.busy", tag, mods[i]), out_busy(i), (m_st[i] == M_RUN) ? 1 : 0);
      chk($sformatf("%s.m%0d.done", tag, mods[i]), out_done(i), (m_st[i] == M_DONE) ? 1 : 0);
    end
  endtask

  // Check tc on the falling edge, clock once, check registered outputs.
  task automatic step(input string tag);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tc_pre[i] = out_tc(i);
      chk($sformatf("%s.m%0d.tc", tag, mods[i]), out_tc(i), model_tc(i));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    check_regs(tag);
  endtask

  task automatic drive(input logic c, input logic s, input logic p, input logic e,
                       input logic d, input logic o, input logic l, input int v);
    clr = c; start = s; stop = p; en = e; dir = d; one_shot = o; load = l;
    lv = 3'(v);
  endtask

  initial begin
    // clr,start,stop,en,dir,os,load,lv | count,tc,wrap,busy,done (MODULUS=3)
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 1, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1, 0, 0, 1, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2, 0, 0, 1, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 1, 1, 1, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1, 0, 0, 1, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2, 0, 0, 1, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 1, 1, 1, 0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 1, 0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset.m3.tc", int'(tc3), 0);
    chk("reset.m5.tc", int'(tc5), 0);
    rst = 1'b0;

    // Basic up-count wrap sequence, enable gating and stop
    for (int k = 0; k < 10; k++) begin
      drive(vecs[k].clr, vecs[k].start, vecs[k].stop, vecs[k].en,
            vecs[k].dir, vecs[k].os, vecs[k].load, int'(vecs[k].lv));
      step($sformatf("vec%0d", k));
      chk($sformatf("vec%0d.tab.tc", k),   tc_pre[0],     vecs[k].e_tc);
      chk($sformatf("vec%0d.tab.count", k), int'(c3),     vecs[k].e_cnt);
      chk($sformatf("vec%0d.tab.wrap", k),  int'(w3),     vecs[k].e_wrap);
      chk($sformatf("vec%0d.tab.busy", k),  int'(b3),     vecs[k].e_busy);
      chk($sformatf("vec%0d.tab.done", k),  int'(d3),     vecs[k].e_done);
    end

    // One-shot down count on MODULUS=5: 4,3,2,1,0 then DONE
    drive(0, 1, 0, 1, 1, 1, 0, 0);
    step("os_start");
    chk("os_start.c5", int'(c5), 4);
    chk("os_start.b5", int'(b5), 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 1, 1, 0, 0);
      step($sformatf("os_dn%0d", k));
      chk($sformatf("os_dn%0d.c5", k), int'(c5), 3 - k);
    end
    step("os_term");
    chk("os_term.tc5", tc_pre[1], 1);
    chk("os_term.d5", int'(d5), 1);
    chk("os_term.b5", int'(b5), 0);
    chk("os_term.c5", int'(c5), 0);
    step("os_hold");
    chk("os_hold.c5", int'(c5), 0);
    chk("os_hold.d5", int'(d5), 1);
    drive(0, 1, 0, 1, 1, 1, 0, 0);
    step("os_restart");
    chk("os_restart.c5", int'(c5), 4);
    chk("os_restart.b5", int'(b5), 1);
    chk("os_restart.d5", int'(d5), 0);

    // Load with clamp while running
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    step("ld_start");
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("ld_up0");
    step("ld_up1");
    chk("ld_up1.c5", int'(c5), 2);
    drive(0, 0, 0, 1, 0, 0, 1, 7);
    step("ld_clamp");
    chk("ld_clamp.c5", int'(c5), 4);
    chk("ld_clamp.b5", int'(b5), 1);
    chk("ld_clamp.c3", int'(c3), 2);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("ld_after");
    chk("ld_after.w5", int'(w5), 1);
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    step("ld_start2");
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("ld_up2");
    step("ld_up3");
    drive(0, 0, 0, 1, 0, 0, 1, 3);
    step("ld_val3");
    chk("ld_val3.c5", int'(c5), 3);
    chk("ld_val3.b5", int'(b5), 1);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("ld_val3_next");
    chk("ld_val3_next.c5", int'(c5), 4);

    // Priority: clr beats load and start; load beats start
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    step("pr_start");
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("pr_up0");
    step("pr_up1");
    drive(1, 1, 0, 1, 0, 0, 1, 5);
    step("pr_clr");
    chk("pr_clr.c5", int'(c5), 0);
    chk("pr_clr.b5", int'(b5), 0);
    drive(0, 1, 0, 1, 0, 0, 1, 3);
    step("pr_load");
    chk("pr_load.c5", int'(c5), 3);
    chk("pr_load.b5", int'(b5), 0);
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    step("pr_start2");
    chk("pr_start2.c5", int'(c5), 0);
    chk("pr_start2.b5", int'(b5), 1);

    // Enable gating and stop on MODULUS=3
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    step("en_start");
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("en_to1");
    step("en_a");
    chk("en_a.c3", int'(c3), 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step("en_b");
    chk("en_b.tc3", tc_pre[0], 0);
    chk("en_b.c3", int'(c3), 2);
    step("en_c");
    chk("en_c.c3", int'(c3), 2);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("en_d");
    chk("en_d.c3", int'(c3), 0);
    chk("en_d.w3", int'(w3), 1);
    step("en_e");
    step("en_f");
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    step("stop");
    chk("stop.b3", int'(b3), 0);
    chk("stop.c3", int'(c3), 2);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("stop_hold");
    chk("stop_hold.tc3", tc_pre[0], 0);
    chk("stop_hold.c3", int'(c3), 2);

    // Asynchronous reset between clock edges mid-run
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    step("ar_start");
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step("ar_up0");
    step("ar_up1");
    chk("ar_up1.c3", int'(c3), 2);
    #1 rst = 1'b1;
    #1;
    chk("arst.c3", int'(c3), 0);
    chk("arst.b3", int'(b3), 0);
    chk("arst.w3", int'(w3), 0);
    chk("arst.d3", int'(d3), 0);
    chk("arst.c5", int'(c5), 0);
    chk("arst.b5", int'(b5), 0);
    model_reset();
    #1 rst = 1'b0;
    step("ar_idle0");
    step("ar_idle1");
    chk("ar_idle1.c3", int'(c3), 0);

    // Randomized run against the reference model
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)));
      step($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
